// File: rtl/perm_pkg.sv
// Shared types and the coordinate mapping for the matrix permutation engine.
package perm_pkg;

  localparam int PERM_D   = 5;
  localparam int PERM_OFS = 3;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  // Destination bit index of source bit i for one forward round.
  // Coordinates are shifted by ofs on entry and by (d-ofs) on exit.
  function automatic int dst_index(input int i, input int d, input int ofs);
    int x;
    int y;
    int nx;
    int ny;
    x  = ((i % d) + ofs) % d;
    y  = ((i / d) + ofs) % d;
    nx = y;
    ny = (2 * x + 3 * y) % d;
    nx = (nx + d - ofs) % d;
    ny = (ny + d - ofs) % d;
    return ny * d + nx;
  endfunction

endpackage

// File: rtl/perm_net.sv
// One combinational permutation round, forward or inverse; pure wiring.
module perm_net
  import perm_pkg::*;
#(
  parameter int D   = PERM_D,
  parameter int OFS = PERM_OFS
) (
  input  logic [D*D-1:0] in,
  input  logic           inv,
  output logic [D*D-1:0] out
);

  logic [D*D-1:0] fwd;
  logic [D*D-1:0] bwd;

  // Each source bit is routed to its mapped position; the inverse reads back through the same map.
  for (genvar i = 0; i < D*D; i++) begin : g_bit
    localparam int DI = dst_index(i, D, OFS);
    assign fwd[DI] = in[i];
    assign bwd[i]  = in[DI];
  end

  assign out = inv ? bwd : fwd;

endmodule

// File: rtl/perm_round_engine.sv
// Multi-round matrix permutation engine with valid/ready on input and output.
// A job is loaded, permuted once per cycle for in_rounds cycles, then held until taken.
module perm_round_engine
  import perm_pkg::*;
#(
  parameter int D   = PERM_D,
  parameter int OFS = PERM_OFS,
  parameter int RW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [D*D-1:0]   in_data,
  input  logic [RW-1:0]    in_rounds,
  input  logic             in_inv,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [D*D-1:0]   out_data,
  output logic             busy,
  output logic [RW-1:0]    rounds_left
);

  localparam int W = D*D;

  state_e          state_q;
  logic [W-1:0]    data_q;
  logic [W-1:0]    round_out;
  logic [RW-1:0]   rounds_q;
  logic            inv_q;
  logic            accept;

  perm_net #(
    .D   (D),
    .OFS (OFS)
  ) u_net (
    .in  (data_q),
    .inv (inv_q),
    .out (round_out)
  );

  // A waiting result being consumed frees the engine in the same cycle, so back-to-back jobs need no bubble.
  assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  // Job control: load on accept, iterate rounds in RUN, hold the result in DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      data_q   <= '0;
      rounds_q <= '0;
      inv_q    <= 1'b0;
    end else if (accept) begin
      data_q   <= in_data;
      inv_q    <= in_inv;
      rounds_q <= in_rounds;
      state_q  <= (in_rounds == '0) ? DONE : RUN;
    end else begin
      case (state_q)
        RUN: begin
          data_q   <= round_out;
          rounds_q <= rounds_q - RW'(1);
          if (rounds_q == RW'(1)) state_q <= DONE;
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: begin
          state_q <= state_q;
        end
      endcase
    end
  end

  assign out_valid   = (state_q == DONE);
  assign busy        = (state_q == RUN);
  assign out_data    = data_q;
  assign rounds_left = rounds_q;

endmodule

// File: tb/tb_perm_round_engine.sv
// Scoreboard bench for perm_round_engine: directed jobs push expected results,
// a monitor pops and compares whenever a result is handed over.
module tb_perm_round_engine;
  import perm_pkg::*;

  localparam int D   = 5;
  localparam int OFS = 3;
  localparam int RW  = 8;
  localparam int W   = D*D;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [RW-1:0] in_rounds;
  logic          in_inv;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          busy;
  logic [RW-1:0] rounds_left;

  typedef struct {
    logic [W-1:0] exp;
    logic [W-1:0] mdl;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  perm_round_engine #(.D(D), .OFS(OFS), .RW(RW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_rounds   (in_rounds),
    .in_inv      (in_inv),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .busy        (busy),
    .rounds_left (rounds_left)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] model(input logic [W-1:0] d, input int n, input bit inv);
    logic [W-1:0] c;
    logic [W-1:0] t;
    c = d;
    for (int k = 0; k < n; k++) begin
      t = '0;
      for (int i = 0; i < W; i++) begin
        if (!inv) t[dst_index(i, D, OFS)] = c[i];
        else      t[i] = c[dst_index(i, D, OFS)];
      end
      c = t;
    end
    return c;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Drive a job and return after the edge that accepts it; waits = cycles spent stalled.
  task automatic send(input logic [W-1:0] d, input int n, input bit inv, input bit push,
                      input logic [W-1:0] exp, output int waits);
    exp_t e;
    if (push) begin
      e.exp = exp;
      e.mdl = model(d, n, inv);
      sb.push_back(e);
    end
    in_data   = d;
    in_rounds = RW'(n);
    in_inv    = inv;
    in_valid  = 1'b1;
    waits     = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waits++;
      if (waits > 1000) begin
        $display("FAIL accept_timeout: got no in_ready, expected in_ready within 1000 cycles");
        $fatal(1, "accept timeout");
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending results, expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every handed-over result is compared against the oldest expectation.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %h, expected no result", out_data);
      end else begin
        mon_e = sb.pop_front();
        check("result", out_data, mon_e.exp);
        check("model", out_data, mon_e.mdl);
      end
    end
  end

  initial begin
    int w;
    logic [W-1:0] r;
    logic [W-1:0] f;
    logic [W-1:0] ones;
    ones      = '1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_rounds = '0;
    in_inv    = 1'b0;
    out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_busy", W'(busy), W'(0));
    check("rst_out_data", out_data, W'(0));
    check("rst_rounds_left", W'(rounds_left), W'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("in_ready_after_rst", W'(in_ready), W'(1));
    @(posedge clk);
    #1;

    // Single forward round and its latency
    send(W'(1), 1, 1'b0, 1'b1, W'(1) << 10, w);
    @(negedge clk);
    check("lat1_not_yet", W'(out_valid), W'(0));
    @(negedge clk);
    check("lat1_valid", W'(out_valid), W'(1));
    drain();

    // Two forward rounds, then one inverse round
    send(W'(1), 2, 1'b0, 1'b1, W'(1) << 17, w);
    send(W'(1) << 10, 1, 1'b1, 1'b1, W'(1), w);
    drain();

    // Fixed centre bit, all-ones, zero-round pass-through
    send(W'(1) << 12, 7, 1'b0, 1'b1, W'(1) << 12, w);
    send(ones, 9, 1'b1, 1'b1, ones, w);
    send(W'(25'h0ABCDEF), 0, 1'b0, 1'b1, W'(25'h0ABCDEF), w);
    @(negedge clk);
    check("lat0_valid", W'(out_valid), W'(1));
    drain();

    // Random data forward 13 rounds, then back through 13 inverse rounds
    for (int k = 0; k < 3; k++) begin
      r = W'($urandom);
      f = model(r, 13, 1'b0);
      send(r, 13, 1'b0, 1'b1, f, w);
      send(f, 13, 1'b1, 1'b1, r, w);
    end
    drain();

    // Back-pressure in DONE, then back-to-back handover
    out_ready = 1'b0;
    send(W'(1), 1, 1'b0, 1'b1, W'(1) << 10, w);
    w = 0;
    while (!out_valid && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("hold_reached_done", W'(out_valid), W'(1));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_data", out_data, W'(1) << 10);
      check("hold_in_ready", W'(in_ready), W'(0));
      check("hold_valid", W'(out_valid), W'(1));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(W'(1) << 10, 2, 1'b1, 1'b1, W'(1) << 4, w);
    check("zero_bubble_waits", W'(w), W'(0));
    check("zero_bubble_busy", W'(busy), W'(1));
    drain();

    // Asynchronous reset in the middle of a run
    send(W'(1), 10, 1'b0, 1'b0, W'(0), w);
    w = 0;
    while (rounds_left != RW'(3) && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("mid_run_rounds_left", W'(rounds_left), W'(3));
    #2;
    rst = 1'b0;
    #1;
    check("arst_out_valid", W'(out_valid), W'(0));
    check("arst_busy", W'(busy), W'(0));
    check("arst_out_data", out_data, W'(0));
    check("arst_rounds_left", W'(rounds_left), W'(0));
    check("arst_in_ready", W'(in_ready), W'(1));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    send(W'(1), 1, 1'b0, 1'b1, W'(1) << 10, w);
    send(W'(1) << 12, 7, 1'b1, 1'b1, W'(1) << 12, w);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
